ascii_dec_counter: RTL and testbench

//  Parametrised multi-lane ASCII-decimal candidate generator for the MD5 cracking datapath.

---
 rtl/md5_pkg.sv | 18 +
 rtl/ascii_dec_add.sv | 29 ++
 rtl/ascii_dec_counter.sv | 108 ++++++++++
 tb/tb_ascii_dec_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 candidate-generation datapath:
// ASCII digit constants, the counter state type and a digit test helper.
package md5_pkg;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic ascii_is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/ascii_dec_add.sv
// Combinational ripple adder of a small constant k (0..9) onto an ASCII decimal string.
// Byte 0 is the least significant digit; carry_out flags a wrap past all-'9'.
module ascii_dec_add
    import md5_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [8*DIGITS-1:0] value,
    input  logic [3:0]          k,
    output logic [8*DIGITS-1:0] sum,
    output logic                carry_out
);

    // k only enters at the least significant digit; higher digits see just the carry.
    always_comb begin
        logic [4:0] t;
        logic       c;
        sum = '0;
        c   = 1'b0;
        t   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            t = 5'(value[8*d +: 8] - ASCII_0) + {4'd0, c} + ((d == 0) ? {1'b0, k} : 5'd0);
            c = (t > 5'd9);
            sum[8*d +: 8] = ASCII_0 + {4'd0, (c ? 4'(t - 5'd10) : t[3:0])};
        end
        carry_out = c;
    end

endmodule

// File: rtl/ascii_dec_counter.sv
// Multi-lane ASCII decimal candidate generator: presents LANES consecutive values per
// batch and sweeps a loaded inclusive [start, end] range under valid/ready flow control.
module ascii_dec_counter
    import md5_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [8*DIGITS-1:0]       start_value,
    input  logic [8*DIGITS-1:0]       end_value,
    input  logic                      enable,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*8*DIGITS-1:0] cand,
    output logic [LANES-1:0]          lane_mask,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    localparam int W = 8 * DIGITS;

    state_e           state_q, state_d;
    logic [W-1:0]     base_q, base_d;
    logic [W-1:0]     end_q, end_d;
    logic [W-1:0]     base_next;
    logic             next_wrap;
    logic [LANES-1:0] lane_wrap;
    logic             last_rule;
    logic             accept;

    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int d = 0; d < DIGITS; d++)
            r[8*d +: 8] = ascii_is_digit(v[8*d +: 8]) ? v[8*d +: 8] : ASCII_0;
        return r;
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ascii_dec_add #(.DIGITS(DIGITS)) u_lane (
            .value     (base_q),
            .k         (4'(i)),
            .sum       (cand[i*W +: W]),
            .carry_out (lane_wrap[i])
        );
        assign lane_mask[i] = !lane_wrap[i] && (cand[i*W +: W] <= end_q);
    end

    ascii_dec_add #(.DIGITS(DIGITS)) u_step (
        .value     (base_q),
        .k         (4'(LANES)),
        .sum       (base_next),
        .carry_out (next_wrap)
    );

    assign last_rule = (lane_mask != {LANES{1'b1}}) || (cand[(LANES-1)*W +: W] == end_q);
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign last      = out_valid && last_rule;
    assign accept    = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= {DIGITS{ASCII_0}};
            end_q   <= {DIGITS{ASCII_9}};
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            end_q   <= end_d;
        end
    end

    // Load overrides everything, including a same-cycle accept whose advance is dropped.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        end_d   = end_q;
        if (load) begin
            state_d = IDLE;
            base_d  = sanitize(start_value);
            end_d   = sanitize(end_value);
        end else begin
            unique case (state_q)
                IDLE: if (enable) state_d = RUN;
                RUN: begin
                    if (accept) begin
                        if (last_rule) begin
                            state_d = DONE;
                        end else begin
                            // A wrapping step always coincides with last, so this never blocks a real advance.
                            if (!next_wrap) base_d = base_next;
                            if (!enable) state_d = IDLE;
                        end
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_dec_counter.sv
// Bench for ascii_dec_counter: directed scenarios on three parameterisations plus a
// randomized run of the 4-digit/3-lane build against an integer-arithmetic reference model.
module tb_ascii_dec_counter;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Instance A: DIGITS=8, LANES=1
    logic        aLoad = 0, aEnable = 0, aReady = 0;
    logic [63:0] aStart = '0, aEnd = '0;
    logic        aValid, aLast, aBusy, aDone;
    logic [63:0] aCand;
    logic [0:0]  aMask;

    // Instance B: DIGITS=4, LANES=3
    logic        bLoad = 0, bEnable = 0, bReady = 0;
    logic [31:0] bStart = '0, bEnd = '0;
    logic        bValid, bLast, bBusy, bDone;
    logic [95:0] bCand;
    logic [2:0]  bMask;

    // Instance C: DIGITS=2, LANES=3
    logic        cLoad = 0, cEnable = 0, cReady = 0;
    logic [15:0] cStart = '0, cEnd = '0;
    logic        cValid, cLast, cBusy, cDone;
    logic [47:0] cCand;
    logic [2:0]  cMask;

    ascii_dec_counter #(.DIGITS(8), .LANES(1)) u_dutA (
        .clk(clk), .reset_n(reset_n), .load(aLoad), .start_value(aStart), .end_value(aEnd),
        .enable(aEnable), .out_valid(aValid), .out_ready(aReady), .cand(aCand),
        .lane_mask(aMask), .last(aLast), .busy(aBusy), .done(aDone));

    ascii_dec_counter #(.DIGITS(4), .LANES(3)) u_dutB (
        .clk(clk), .reset_n(reset_n), .load(bLoad), .start_value(bStart), .end_value(bEnd),
        .enable(bEnable), .out_valid(bValid), .out_ready(bReady), .cand(bCand),
        .lane_mask(bMask), .last(bLast), .busy(bBusy), .done(bDone));

    ascii_dec_counter #(.DIGITS(2), .LANES(3)) u_dutC (
        .clk(clk), .reset_n(reset_n), .load(cLoad), .start_value(cStart), .end_value(cEnd),
        .enable(cEnable), .out_valid(cValid), .out_ready(cReady), .cand(cCand),
        .lane_mask(cMask), .last(cLast), .busy(cBusy), .done(cDone));

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [63:0] s, input logic [63:0] e,
                                 input logic en, input logic rdy);
        aLoad = ld; aStart = s; aEnd = e; aEnable = en; aReady = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stepB();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference helpers: decimal integers <-> ASCII strings, non-digit bytes read as 0.
    function automatic logic [127:0] toAscii(input int n, input int d);
        logic [127:0] r;
        int v;
        r = '0;
        v = n;
        for (int k = 0; k < d; k++) begin
            r[8*k +: 8] = 8'(48 + v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int fromAscii(input logic [127:0] v, input int d);
        int n;
        logic [7:0] b;
        n = 0;
        for (int k = d - 1; k >= 0; k--) begin
            b = v[8*k +: 8];
            n = n * 10 + (((b >= 8'h30) && (b <= 8'h39)) ? int'(b - 8'h30) : 0);
        end
        return n;
    endfunction

    function automatic logic [127:0] expCandB(input int base);
        logic [127:0] r;
        logic [127:0] t;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            t = toAscii((base + i) % 10000, 4);
            r[32*i +: 32] = t[31:0];
        end
        return r;
    endfunction

    function automatic logic [2:0] expMaskB(input int base, input int lim);
        logic [2:0] m;
        for (int i = 0; i < 3; i++)
            m[i] = ((base + i) <= 9999) && ((base + i) <= lim);
        return m;
    endfunction

    function automatic logic expLastB(input int base, input int lim);
        return (expMaskB(base, lim) != 3'b111) || ((base + 2) == lim);
    endfunction

    int  mBase, mEnd;
    bit  mRun, mDone;
    logic [127:0] tmp;

    initial begin
        // Reset values
        #1 reset_n = 1'b0;
        #2;
        checkOutput("rstA_valid", 128'(aValid), 128'(0));
        checkOutput("rstA_busy",  128'(aBusy),  128'(0));
        checkOutput("rstA_done",  128'(aDone),  128'(0));
        checkOutput("rstA_last",  128'(aLast),  128'(0));
        checkOutput("rstA_cand",  128'(aCand),  128'("00000000"));
        checkOutput("rstB_cand",  128'(bCand),  128'({"0002", "0001", "0000"}));
        checkOutput("rstB_mask",  128'(bMask),  128'(3'b111));
        @(negedge clk);
        reset_n = 1'b1;

        // T1: single lane sweep 9..11
        applyStimulus(1, "00000009", "00000011", 0, 0);
        applyStimulus(0, '0, '0, 1, 1);
        checkOutput("t1_valid0", 128'(aValid), 128'(1));
        checkOutput("t1_cand0",  128'(aCand),  128'("00000009"));
        checkOutput("t1_last0",  128'(aLast),  128'(0));
        applyStimulus(0, '0, '0, 1, 1);
        checkOutput("t1_cand1",  128'(aCand),  128'("00000010"));
        checkOutput("t1_last1",  128'(aLast),  128'(0));
        applyStimulus(0, '0, '0, 1, 1);
        checkOutput("t1_cand2",  128'(aCand),  128'("00000011"));
        checkOutput("t1_last2",  128'(aLast),  128'(1));
        applyStimulus(0, '0, '0, 1, 1);
        checkOutput("t1_done",   128'(aDone),  128'(1));
        checkOutput("t1_valid3", 128'(aValid), 128'(0));

        // T4: backpressure holds the batch, enable drop ignored until accept
        applyStimulus(1, "00000100", "00000200", 0, 0);
        checkOutput("t4_doneclr", 128'(aDone), 128'(0));
        applyStimulus(0, '0, '0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, '0, '0, 0, 0);
            checkOutput("t4_holdvalid", 128'(aValid), 128'(1));
            checkOutput("t4_holdcand",  128'(aCand),  128'("00000100"));
        end
        applyStimulus(0, '0, '0, 0, 1);
        checkOutput("t4_pausevalid", 128'(aValid), 128'(0));
        checkOutput("t4_pausecand",  128'(aCand),  128'("00000101"));

        // T5: load coincident with accept wins
        applyStimulus(0, '0, '0, 1, 1);
        checkOutput("t5_resume", 128'(aCand), 128'("00000101"));
        applyStimulus(1, "00000012", "00000099", 1, 1);
        checkOutput("t5_cand",  128'(aCand),  128'("00000012"));
        checkOutput("t5_valid", 128'(aValid), 128'(0));
        checkOutput("t5_done",  128'(aDone),  128'(0));

        // T6: non-digit bytes load as '0'
        applyStimulus(1, "00A00012", "0000002Z", 0, 0);
        checkOutput("t6_cand", 128'(aCand), 128'("00000012"));
        applyStimulus(0, '0, '0, 1, 1);
        for (int n = 12; n <= 20; n++) begin
            checkOutput("t6_sweep", 128'(aCand), toAscii(n, 8));
            checkOutput("t6_last",  128'(aLast), 128'(n == 20));
            applyStimulus(0, '0, '0, 1, 1);
        end
        checkOutput("t6_done", 128'(aDone), 128'(1));

        // T7: asynchronous reset mid-batch
        applyStimulus(1, "00000500", "00000900", 0, 0);
        applyStimulus(0, '0, '0, 1, 1);
        applyStimulus(0, '0, '0, 1, 1);
        checkOutput("t7_pre", 128'(aCand), 128'("00000501"));
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t7_valid", 128'(aValid), 128'(0));
        checkOutput("t7_busy",  128'(aBusy),  128'(0));
        checkOutput("t7_last",  128'(aLast),  128'(0));
        checkOutput("t7_cand",  128'(aCand),  128'("00000000"));
        checkOutput("t7_mask",  128'(aMask),  128'(1));
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(0, '0, '0, 0, 0);
        checkOutput("t7_idle", 128'(aValid), 128'(0));

        // T2: DIGITS=4 LANES=3 across a decade carry
        bLoad = 1; bStart = "0998"; bEnd = "1003";
        stepB();
        bLoad = 0; bEnable = 1; bReady = 1;
        stepB();
        checkOutput("t2_cand1", 128'(bCand), 128'({"1000", "0999", "0998"}));
        checkOutput("t2_mask1", 128'(bMask), 128'(3'b111));
        checkOutput("t2_last1", 128'(bLast), 128'(0));
        stepB();
        checkOutput("t2_cand2", 128'(bCand), 128'({"1003", "1002", "1001"}));
        checkOutput("t2_mask2", 128'(bMask), 128'(3'b111));
        checkOutput("t2_last2", 128'(bLast), 128'(1));
        stepB();
        checkOutput("t2_done", 128'(bDone), 128'(1));
        bEnable = 0; bReady = 0;

        // T3: DIGITS=2 LANES=3 wrap past "99"
        cLoad = 1; cStart = "98"; cEnd = "99";
        stepB();
        cLoad = 0; cEnable = 1; cReady = 1;
        stepB();
        checkOutput("t3_cand", 128'(cCand), 128'({"00", "99", "98"}));
        checkOutput("t3_mask", 128'(cMask), 128'(3'b011));
        checkOutput("t3_last", 128'(cLast), 128'(1));
        stepB();
        checkOutput("t3_done", 128'(cDone), 128'(1));
        cEnable = 0; cReady = 0;

        // Randomized run of instance B against the integer model
        mBase = 0; mEnd = 9999; mRun = 0; mDone = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  sVal, eVal, p;
            logic lastNow;
            bLoad   = (cyc == 0) || ($urandom_range(0, 19) == 0);
            bEnable = ($urandom_range(0, 99) < 85);
            bReady  = ($urandom_range(0, 99) < 70);
            sVal = ($urandom_range(0, 3) == 0) ? 9990 + int'($urandom_range(0, 9))
                                               : int'($urandom_range(0, 9999));
            eVal = sVal + int'($urandom_range(0, 14)) - 2;
            if (eVal < 0) eVal = 0;
            if (eVal > 9999) eVal = 9999;
            tmp = toAscii(sVal, 4);
            bStart = tmp[31:0];
            tmp = toAscii(eVal, 4);
            bEnd = tmp[31:0];
            if ($urandom_range(0, 4) == 0) begin
                p = int'($urandom_range(0, 3));
                bStart[8*p +: 8] = 8'($urandom_range(0, 255));
            end

            lastNow = expLastB(mBase, mEnd);
            if (bLoad) begin
                mBase = fromAscii(128'(bStart), 4);
                mEnd  = fromAscii(128'(bEnd), 4);
                mRun  = 0;
                mDone = 0;
            end else if (mRun) begin
                if (bReady) begin
                    if (lastNow) begin
                        mRun  = 0;
                        mDone = 1;
                    end else begin
                        mBase = mBase + 3;
                        if (!bEnable) mRun = 0;
                    end
                end
            end else if (!mDone && bEnable) begin
                mRun = 1;
            end

            stepB();
            checkOutput("rnd_valid", 128'(bValid), 128'(mRun));
            checkOutput("rnd_busy",  128'(bBusy),  128'(mRun));
            checkOutput("rnd_done",  128'(bDone),  128'(mDone));
            checkOutput("rnd_cand",  128'(bCand),  expCandB(mBase));
            checkOutput("rnd_mask",  128'(bMask),  128'(expMaskB(mBase, mEnd)));
            checkOutput("rnd_last",  128'(bLast),  128'(mRun && expLastB(mBase, mEnd)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
